// File: rtl/note_pkg.sv
// Shared types and song contents for note_sequencer and its ROM.
// The song table below is the ROM init image read by song_rom.
package note_pkg;

  localparam int NOTE_BITS     = 6;
  localparam logic [NOTE_BITS-1:0] NOTE_REST = 6'd0;
  localparam int SONG_BITS_DEF = 2;
  localparam int IDX_BITS_DEF  = 5;
  localparam int DUR_BITS_DEF  = 6;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

  typedef struct packed {
    logic [NOTE_BITS-1:0] note;
    int                   dur;
  } entry_t;

  // dur = 0 marks the end of a song; unlisted entries are end markers
  function automatic entry_t song_entry(input int song, input int idx);
    entry_t e;
    e = '{NOTE_REST, 0};
    case (song)
      0: case (idx)
           0: e = '{6'd13, 2};
           1: e = '{6'd40, 1};
           default: ;
         endcase
      1: e = '{NOTE_BITS'(idx + 1), 1};
      2: case (idx)
           0: e = '{6'd13, 3};
           1: e = '{6'd20, 1};
           2: e = '{6'd5, 1};
           3: e = '{6'd6, 1};
           4: e = '{6'd55, 4};
           default: ;
         endcase
      3: if (idx == 0) e = '{6'd50, 1};
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Synchronous song ROM: one-cycle registered read of {note, dur}.
module song_rom
  import note_pkg::*;
#(
  parameter int AW    = 7,
  parameter int DW    = 12,
  parameter int IDX_W = 5
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  localparam int DUR_W = DW - NOTE_BITS;

  entry_t entry;

  always_comb entry = song_entry(int'(addr[AW-1:IDX_W]), int'(addr[IDX_W-1:0]));

  always_ff @(posedge clk) begin
    data <= {entry.note, DUR_W'(entry.dur)};
  end

endmodule

// File: rtl/note_sequencer.sv
// Beat-driven song stepper feeding the note display stage.
// Build option NOTE_SEQ_REPEAT_EN: loop the song instead of stopping in DONE.
module note_sequencer
  import note_pkg::*;
#(
  parameter int SONG_BITS = SONG_BITS_DEF,
  parameter int IDX_BITS  = IDX_BITS_DEF,
  parameter int DUR_BITS  = DUR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 beat,
  input  logic [SONG_BITS-1:0] song_sel,
  output logic [NOTE_BITS-1:0] note,
  output logic                 new_note,
  output logic [IDX_BITS-1:0]  note_idx,
  output logic                 busy,
  output logic                 song_done,
  output state_t               dbg_state
);

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
`ifdef NOTE_SEQ_REPEAT_EN
  localparam state_t END_STATE = FETCH;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t                          state, state_nx;
  logic [SONG_BITS-1:0]            song_q;
  logic [IDX_BITS-1:0]             idx;
  logic [DUR_BITS-1:0]             cnt;
  logic [NOTE_BITS-1:0]            note_r;
  logic [IDX_BITS-1:0]             idx_r;
  logic                            load_q;
  logic [SONG_BITS+IDX_BITS-1:0]   rom_addr;
  logic [NOTE_BITS+DUR_BITS-1:0]   rom_data;
  logic [NOTE_BITS-1:0]            rom_note;
  logic [DUR_BITS-1:0]             rom_dur;
  logic                            beat_ok, last_beat, at_end, to_done;

  assign rom_addr            = {song_q, idx};
  assign {rom_note, rom_dur} = rom_data;
  assign beat_ok             = (state == PLAY) && play && beat;
  assign last_beat           = beat_ok && (cnt == DUR_BITS'(1));
  // End of song: marker seen in LOAD, or final beat of the last index
  assign at_end = ((state == LOAD) && (rom_dur == '0)) || (last_beat && (idx == IDX_LAST));

  song_rom #(
    .AW    (SONG_BITS + IDX_BITS),
    .DW    (NOTE_BITS + DUR_BITS),
    .IDX_W (IDX_BITS)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (play) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = at_end ? END_STATE : PLAY;
      PLAY:    if (last_beat) state_nx = at_end ? END_STATE : FETCH;
      DONE:    if (!play) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == FETCH) || (state == LOAD) || (state == PLAY);
    dbg_state = state;
`ifdef NOTE_SEQ_REPEAT_EN
    song_done = 1'b0;
    to_done   = 1'b0;
`else
    song_done = (state == DONE);
    to_done   = at_end;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song_q <= '0;
      idx    <= '0;
      cnt    <= '0;
      note_r <= NOTE_REST;
      idx_r  <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state)
        IDLE: if (play) begin
          song_q <= song_sel;
          idx    <= '0;
        end
        LOAD: if (at_end) begin
`ifdef NOTE_SEQ_REPEAT_EN
          idx    <= '0;
`else
          note_r <= NOTE_REST;
`endif
        end else begin
          note_r <= rom_note;
          cnt    <= rom_dur;
          idx_r  <= idx;
          load_q <= 1'b1;
        end
        PLAY: if (beat_ok) begin
          // The counter stops at 1; the next note reloads it
          if (cnt == DUR_BITS'(1)) begin
            if (at_end) begin
`ifdef NOTE_SEQ_REPEAT_EN
              idx    <= '0;
`else
              note_r <= NOTE_REST;
`endif
            end else begin
              idx <= idx + IDX_BITS'(1);
            end
          end else begin
            cnt <= cnt - DUR_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage: note and new_note land together; DONE blanks at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note     <= NOTE_REST;
      new_note <= 1'b0;
      note_idx <= '0;
    end else begin
      note     <= to_done ? NOTE_REST : note_r;
      new_note <= load_q;
      note_idx <= idx_r;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: song-0 vector table plus hand sequences
// for pause, dropped beats, song_sel latching, reset and the 32-entry song.
module tb_note_sequencer;
  import note_pkg::*;

  logic       clk, reset, play, beat;
  logic [1:0] song_sel;
  logic [5:0] note;
  logic       new_note, busy, song_done;
  logic [4:0] note_idx;
  state_t     dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       play;
    logic       beat;
    logic [1:0] sel;
    logic [5:0] note;
    logic       nn;
    logic [4:0] idx;
    logic       busy;
    logic       done;
  } vec_t;

  localparam int NV = 17;
  vec_t       vecs[NV];
  logic [5:0] exp_q[$];
  logic [5:0] exp_n;

  note_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .beat      (beat),
    .song_sel  (song_sel),
    .note      (note),
    .new_note  (new_note),
    .note_idx  (note_idx),
    .busy      (busy),
    .song_done (song_done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [5:0] en, input logic enn,
                           input logic [4:0] eidx, input logic eb, input logic ed);
    checks++;
    if (note !== en || new_note !== enn || note_idx !== eidx || busy !== eb || song_done !== ed) begin
      failures++;
      $display("FAIL %s: got note=%0d new=%0d idx=%0d busy=%0d done=%0d, expected note=%0d new=%0d idx=%0d busy=%0d done=%0d",
               name, note, new_note, note_idx, busy, song_done, en, enn, eidx, eb, ed);
    end
  endtask

  task automatic do_reset();
    play  = 1'b0;
    beat  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One accepted-or-ignored beat edge followed by n quiet edges
  task automatic beat_then(input int n);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic vec_t mk(input logic p, input logic b, input logic [1:0] s, input logic [5:0] n,
                              input logic nn, input logic [4:0] ix, input logic bz, input logic d);
    return '{p, b, s, n, nn, ix, bz, d};
  endfunction

  initial begin
    // Song 0: 13 for 2 beats, 40 for 1 beat, then end marker.
    // Beats on rows 0, 9, 10, 13 fall in IDLE/FETCH/LOAD and must be ignored.
    vecs[0]  = mk(1, 1, 0,  0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 0,  0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 0, 0,  0, 0, 0, 1, 0);
    vecs[3]  = mk(1, 0, 0, 13, 1, 0, 1, 0);
    vecs[4]  = mk(1, 1, 0, 13, 0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 13, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 0, 13, 0, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0, 13, 0, 0, 1, 0);
    vecs[8]  = mk(1, 1, 0, 13, 0, 0, 1, 0);
    vecs[9]  = mk(1, 1, 0, 13, 0, 0, 1, 0);
    vecs[10] = mk(1, 1, 0, 13, 0, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 40, 1, 1, 1, 0);
    vecs[12] = mk(1, 1, 0, 40, 0, 1, 1, 0);
    vecs[13] = mk(1, 1, 0, 40, 0, 1, 1, 0);
`ifdef NOTE_SEQ_REPEAT_EN
    vecs[14] = mk(1, 1, 0, 40, 0, 1, 1, 0);
    vecs[15] = mk(1, 0, 0, 40, 0, 1, 1, 0);
    vecs[16] = mk(0, 0, 0, 40, 0, 1, 1, 0);
`else
    vecs[14] = mk(1, 1, 0,  0, 0, 1, 0, 1);
    vecs[15] = mk(1, 0, 0,  0, 0, 1, 0, 1);
    vecs[16] = mk(0, 0, 0,  0, 0, 1, 0, 0);
`endif

    reset    = 1'b0;
    play     = 1'b0;
    beat     = 1'b0;
    song_sel = 2'd0;
    tick();
    check_out("reset_state", 0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      play     = vecs[i].play;
      beat     = vecs[i].beat;
      song_sel = vecs[i].sel;
      tick();
      check_out($sformatf("song0_row%0d", i), vecs[i].note, vecs[i].nn, vecs[i].idx,
                vecs[i].busy, vecs[i].done);
    end
    beat = 1'b0;

    // Pause: note 13 (dur 3), one beat, then play low with a coincident beat
    do_reset();
    song_sel = 2'd2;
    play     = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_out("song2_first", 13, 1, 0, 1, 0);
    beat_then(0);
    check_out("first_beat", 13, 0, 0, 1, 0);
    play = 1'b0;
    beat_then(0);
    check_out("beat_at_pause", 13, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      beat_then(1);
      check_out($sformatf("paused_%0d", k), 13, 0, 0, 1, 0);
    end
    play = 1'b1;
    beat_then(1);
    check_out("resume_beat1", 13, 0, 0, 1, 0);
    beat_then(2);
    check_out("refill_no_gap", 13, 0, 0, 1, 0);
    tick();
    check_out("note20", 20, 1, 1, 1, 0);

    // song_sel change during PLAY must not affect song 2
    song_sel = 2'd3;
    beat_then(3);
    check_out("note5", 5, 1, 2, 1, 0);
    beat_then(3);
    check_out("note6", 6, 1, 3, 1, 0);
    beat_then(3);
    check_out("note55", 55, 1, 4, 1, 0);
    beat_then(0);
    check_out("note55_mid", 55, 0, 4, 1, 0);

    // Asynchronous reset mid-note; release with play high restarts song 3
    #2 reset = 1'b0;
    #1 check_out("async_reset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check_out("restart_pre", 0, 0, 0, 1, 0);
    tick();
    check_out("restart_song3", 50, 1, 0, 1, 0);
    beat_then(2);
`ifdef NOTE_SEQ_REPEAT_EN
    check_out("song3_loop_hold", 50, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) tick();
    check_out("song3_loop", 50, 1, 0, 1, 0);
`else
    check_out("song3_done", 0, 0, 0, 0, 1);
    play     = 1'b0;
    song_sel = 2'd1;
    tick();
    check_out("done_to_idle", 0, 0, 0, 0, 0);
    play = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_out("song1_after_done", 1, 1, 0, 1, 0);
`endif

    // Song 1: 32 entries of dur 1, notes 1..32, no end marker
    do_reset();
    song_sel = 2'd1;
    play     = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_out("song1_entry0", 1, 1, 0, 1, 0);
    for (int n = 2; n <= 32; n++) exp_q.push_back(6'(n));
    for (int i = 0; i < 31; i++) begin
      beat_then(3);
      exp_n = exp_q.pop_front();
      check_out($sformatf("song1_entry%0d", i + 1), exp_n, 1, 5'(i + 1), 1, 0);
    end
    beat_then(0);
`ifdef NOTE_SEQ_REPEAT_EN
    check_out("song1_wrap_hold", 32, 0, 31, 1, 0);
    for (int k = 0; k < 3; k++) tick();
    check_out("song1_wrap", 1, 1, 0, 1, 0);
`else
    check_out("song1_last_done", 0, 0, 31, 0, 1);
    tick();
    check_out("song1_stays_done", 0, 0, 31, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
